// File: rtl/switch_event_fifo.sv
// Turns debounced switch level changes into {polarity, index} events
// and queues them in a small FIFO read by the control FSM.
module switch_event_fifo #(
  parameter int NSW   = 4,
  parameter int IW    = 2,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [NSW-1:0] sw_level,
  input  logic [NSW-1:0] sw_ready,
  input  logic          ev_pop,
  input  logic          ovr_clr,
  output logic [IW:0]   ev_data,
  output logic          ev_valid,
  output logic [AW:0]   ev_count,
  output logic          overrun
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [NSW-1:0] last_level, last_level_n;
  logic [NSW-1:0] pend, pend_n;
  logic [NSW-1:0] pend_pol, pend_pol_n;
  logic [NSW-1:0] chg;
  logic [IW:0]    mem [DEPTH];
  logic [AW-1:0]  wptr, rptr;
  logic [IW-1:0]  sel;
  logic           has_sel;
  logic           pop_fire;
  logic           push_ok;
  logic           push;
  logic           ovr_set;

  assign chg      = sw_ready & (sw_level ^ last_level);
  assign ev_valid = (ev_count != '0);
  assign ev_data  = mem[rptr];
  assign pop_fire = ev_pop & ev_valid;
  assign push_ok  = (ev_count < FULL) | pop_fire;
  assign push     = has_sel & push_ok;

  // Lowest-index pending switch wins.
  always_comb begin
    sel     = '0;
    has_sel = 1'b0;
    for (int i = NSW - 1; i >= 0; i--) begin
      if (pend[i]) begin
        sel     = IW'(i);
        has_sel = 1'b1;
      end
    end
  end

  always_comb begin
    last_level_n = last_level;
    pend_n       = pend;
    pend_pol_n   = pend_pol;
    ovr_set      = 1'b0;
    if (push) pend_n[sel] = 1'b0;
    for (int i = 0; i < NSW; i++) begin
      if (chg[i]) begin
        last_level_n[i] = sw_level[i];
        pend_n[i]       = 1'b1;
        pend_pol_n[i]   = sw_level[i];
        // A same-cycle push frees the slot, so that is not a loss.
        if (pend[i] && !(push && (sel == IW'(i))))
          ovr_set = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_level <= '0;
      pend       <= '0;
      pend_pol   <= '0;
      overrun    <= 1'b0;
    end else begin
      last_level <= last_level_n;
      pend       <= pend_n;
      pend_pol   <= pend_pol_n;
      if (ovr_set)      overrun <= 1'b1;
      else if (ovr_clr) overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      ev_count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= {pend_pol[sel], sel};
        wptr      <= wptr + AW'(1);
      end
      if (pop_fire) rptr <= rptr + AW'(1);
      unique case ({push, pop_fire})
        2'b10:   ev_count <= ev_count + (AW+1)'(1);
        2'b01:   ev_count <= ev_count - (AW+1)'(1);
        default: ev_count <= ev_count;
      endcase
    end
  end

endmodule
